// File: rtl/alu_pkg.sv
// Shared ALU definitions: native op encodings, extended divide op codes and the
// alu_ctrl sequencer state enum.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_NOT   = 4'd7;
  localparam logic [3:0] ALU_CMP   = 4'd8;
  localparam logic [3:0] ALU_TEST  = 4'd9;
  localparam logic [3:0] ALU_SHL   = 4'd12;
  localparam logic [3:0] ALU_SHR   = 4'd13;
  localparam logic [3:0] ALU_MULLO = 4'd14;
  localparam logic [3:0] ALU_MULHI = 4'd15;

  localparam logic [4:0] OP_DIVU = 5'h10;
  localparam logic [4:0] OP_REMU = 5'h11;
  localparam logic [4:0] OP_DIV  = 5'h12;
  localparam logic [4:0] OP_REM  = 5'h13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_NEG_A = 3'd2,
    ST_NEG_B = 3'd3,
    ST_ITER  = 3'd4,
    ST_FIX   = 3'd5,
    ST_RESP  = 3'd6
  } ctrl_state_e;

  function automatic logic is_divide(input logic [4:0] op);
    return (op >= OP_DIVU) && (op <= OP_REM);
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Sequencer in front of the shared 32-bit ALU: one-cycle native ops, restoring divide
// over SUB. Define ALU_CTRL_SIGNED_EN to make 0x12/0x13 signed DIV/REM.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_zero,
  output logic        rsp_negative,
  output logic        rsp_divzero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_is_zero,
  input  logic        alu_is_negative,
  output ctrl_state_e dbg_state
);

  // Both channels transfer on a cycle where valid && ready at the rising edge; a
  // response, once valid, holds rsp_* stable until rsp_ready is seen.

  ctrl_state_e state_q;
  logic [4:0]  op_q;
  logic [31:0] a_q, d_q, q_q, r_q;
  logic [4:0]  cnt_q;
  logic [31:0] rsp_c_q;
  logic        rsp_valid_q, rsp_zero_q, rsp_neg_q, rsp_dz_q;
`ifdef ALU_CTRL_SIGNED_EN
  logic        sa_q, sb_q;
  logic [31:0] fix_sel, fix_res;
  logic        fix_neg;
`endif

  logic [31:0] x_d, r_d, q_d, brw_vec, iter_res, dz_res;
  logic        take;

  // One restoring step: shift {R,Q} left, try R-D on the ALU, keep it if no borrow.
  always_comb begin
    x_d      = {r_q[30:0], q_q[31]};
    brw_vec  = (~x_d & d_q) | (~(x_d ^ d_q) & alu_c);
    take     = r_q[31] | ~brw_vec[31];
    r_d      = take ? alu_c : x_d;
    q_d      = {q_q[30:0], take};
    iter_res = op_q[0] ? r_d : q_d;
    dz_res   = op_q[0] ? a_q : 32'hFFFF_FFFF;
`ifdef ALU_CTRL_SIGNED_EN
    fix_sel  = op_q[0] ? r_q : q_q;
    fix_neg  = op_q[0] ? sa_q : (sa_q ^ sb_q);
    fix_res  = fix_neg ? alu_c : fix_sel;
`endif
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    case (state_q)
      ST_EXEC: begin
        if (!op_q[4]) begin
          alu_op = op_q[3:0];
          alu_a  = a_q;
          alu_b  = d_q;
        end
      end
      ST_ITER: begin
        alu_op = ALU_SUB;
        alu_a  = x_d;
        alu_b  = d_q;
      end
`ifdef ALU_CTRL_SIGNED_EN
      ST_NEG_A: begin
        alu_op = ALU_SUB;
        alu_b  = a_q;
      end
      ST_NEG_B: begin
        alu_op = ALU_SUB;
        alu_b  = d_q;
      end
      ST_FIX: begin
        alu_op = ALU_SUB;
        alu_b  = fix_sel;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      rsp_c_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_dz_q    <= 1'b0;
`ifdef ALU_CTRL_SIGNED_EN
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            d_q   <= req_b;
            q_q   <= req_a;
            r_q   <= '0;
            cnt_q <= 5'd31;
`ifdef ALU_CTRL_SIGNED_EN
            sa_q  <= req_a[31];
            sb_q  <= req_b[31];
`endif
            if (!is_divide(req_op) || (req_b == '0)) state_q <= ST_EXEC;
`ifdef ALU_CTRL_SIGNED_EN
            else if (req_op[1]) state_q <= ST_NEG_A;
`endif
            else state_q <= ST_ITER;
          end
        end
        ST_EXEC: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
          if (!op_q[4]) begin
            rsp_c_q    <= alu_c;
            rsp_zero_q <= alu_is_zero;
            rsp_neg_q  <= alu_is_negative;
            rsp_dz_q   <= 1'b0;
          end else if (is_divide(op_q)) begin
            rsp_c_q    <= dz_res;
            rsp_zero_q <= (dz_res == '0);
            rsp_neg_q  <= dz_res[31];
            rsp_dz_q   <= 1'b1;
          end else begin
            rsp_c_q    <= '0;
            rsp_zero_q <= 1'b1;
            rsp_neg_q  <= 1'b0;
            rsp_dz_q   <= 1'b0;
          end
        end
`ifdef ALU_CTRL_SIGNED_EN
        ST_NEG_A: begin
          q_q     <= a_q[31] ? alu_c : a_q;
          state_q <= ST_NEG_B;
        end
        ST_NEG_B: begin
          d_q     <= d_q[31] ? alu_c : d_q;
          state_q <= ST_ITER;
        end
        ST_FIX: begin
          rsp_c_q     <= fix_res;
          rsp_zero_q  <= (fix_res == '0);
          rsp_neg_q   <= fix_res[31];
          rsp_dz_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
`endif
        ST_ITER: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) begin
`ifdef ALU_CTRL_SIGNED_EN
            if (op_q[1]) begin
              state_q <= ST_FIX;
            end else
`endif
            begin
              rsp_c_q     <= iter_res;
              rsp_zero_q  <= (iter_res == '0);
              rsp_neg_q   <= iter_res[31];
              rsp_dz_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_c        = rsp_c_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_negative = rsp_neg_q;
  assign rsp_divzero  = rsp_dz_q;
  assign dbg_state    = state_q;

endmodule
